// File: rtl/matrix_pkg.sv
// matrix_pkg: geometry constants, pixel/coordinate types and frame-store FSM states
package matrix_pkg;
  localparam int MTX_W = 16;
  localparam int MTX_H = 16;
  localparam int PIX_W = 2;
  localparam int NPIX = MTX_W * MTX_H;
  localparam int ADDR_W = $clog2(NPIX);
  typedef logic [3:0] coord_t;
  typedef logic [PIX_W-1:0] pix_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef enum logic [1:0] {IDLE, CLEAR, SWAP_WAIT} fs_state_t;
endpackage

// File: rtl/pix_bank_16x16.sv
// pix_bank_16x16: 256 x 2-bit pixel bank, synchronous write, registered read (read-before-write)
module pix_bank_16x16
  import matrix_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  we_i,
  input  addr_t waddr_i,
  input  pix_t  wdata_i,
  input  addr_t raddr_i,
  output pix_t  rdata_o
);
  pix_t [NPIX-1:0] mem_q;
  pix_t rdata_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '0;
      rdata_q <= '0;
    end else begin
      rdata_q <= mem_q[raddr_i];
      if (we_i) mem_q[waddr_i] <= wdata_i;
    end
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/frame_store_16x16.sv
// frame_store_16x16: double-buffered 16x16 2-bit frame store with bulk clear and
// frame-synchronised bank swap.
module frame_store_16x16
  import matrix_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   wr_valid,
  output logic   wr_ready,
  input  coord_t wr_x,
  input  coord_t wr_y,
  input  pix_t   wr_pix,
  input  logic   clr_req,
  input  pix_t   clr_pix,
  input  logic   swap_req,
  input  logic   frame_end,
  input  coord_t rd_x,
  input  coord_t rd_y,
  output pix_t   rd_pix,
  output logic   front_bank,
  output logic   swap_pending,
  output logic   busy
);
  fs_state_t state_q, state_d;
  logic front_q, front_d, pend_q, pend_d, rd_sel_q;
  addr_t cnt_q, cnt_d, waddr;
  pix_t clr_val_q, clr_val_d, wdata, rd0, rd1;
  logic we;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      front_q   <= 1'b0;
      pend_q    <= 1'b0;
      cnt_q     <= '0;
      clr_val_q <= '0;
      rd_sel_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      front_q   <= front_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
      clr_val_q <= clr_val_d;
      rd_sel_q  <= front_q;
    end
  end
  always_comb begin
    state_d   = state_q;
    front_d   = front_q;
    pend_d    = pend_q;
    cnt_d     = cnt_q;
    clr_val_d = clr_val_q;
    we        = 1'b0;
    waddr     = {wr_y, wr_x};
    wdata     = wr_pix;
    case (state_q)
      IDLE: begin
        we = wr_valid;
        if (clr_req) begin
          clr_val_d = clr_pix;
          cnt_d     = '0;
          pend_d    = swap_req;
          state_d   = CLEAR;
        end else if (swap_req) begin
          pend_d  = 1'b1;
          state_d = SWAP_WAIT;
        end
      end
      CLEAR: begin
        we     = 1'b1;
        waddr  = cnt_q;
        wdata  = clr_val_q;
        cnt_d  = cnt_q + 1'b1;
        pend_d = pend_q | swap_req;
        if (cnt_q == addr_t'(NPIX - 1)) state_d = pend_d ? SWAP_WAIT : IDLE;
      end
      SWAP_WAIT: begin
        if (frame_end) begin
          front_d = ~front_q;
          pend_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // the back bank is always the one not being displayed
  pix_bank_16x16 u_bank0 (
    .clk(clk), .rst_n(rst_n), .we_i(we & front_q), .waddr_i(waddr),
    .wdata_i(wdata), .raddr_i({rd_y, rd_x}), .rdata_o(rd0)
  );
  pix_bank_16x16 u_bank1 (
    .clk(clk), .rst_n(rst_n), .we_i(we & ~front_q), .waddr_i(waddr),
    .wdata_i(wdata), .raddr_i({rd_y, rd_x}), .rdata_o(rd1)
  );
  assign rd_pix       = rd_sel_q ? rd1 : rd0;
  assign front_bank   = front_q;
  assign swap_pending = pend_q;
  assign wr_ready     = state_q == IDLE;
  assign busy         = state_q != IDLE;
endmodule

// File: tb/tb_frame_store_16x16.sv
// tb_frame_store_16x16: directed scenarios plus randomized traffic against a bank-array reference model
module tb_frame_store_16x16;
  logic clk, rst_n, wr_valid, wr_ready, clr_req, swap_req, frame_end;
  logic front_bank, swap_pending, busy;
  logic [3:0] wr_x, wr_y, rd_x, rd_y;
  logic [1:0] wr_pix, clr_pix, rd_pix;
  int n_chk = 0, n_fail = 0;
  logic [1:0] mbank[2][256];
  int mfront, mclear;
  logic mpend, mwait;
  logic [1:0] mclrv, exp_rd;

  frame_store_16x16 dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_x(wr_x), .wr_y(wr_y), .wr_pix(wr_pix), .clr_req(clr_req), .clr_pix(clr_pix),
    .swap_req(swap_req), .frame_end(frame_end), .rd_x(rd_x), .rd_y(rd_y),
    .rd_pix(rd_pix), .front_bank(front_bank), .swap_pending(swap_pending), .busy(busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset;
    for (int b = 0; b < 2; b++) for (int a = 0; a < 256; a++) mbank[b][a] = 0;
    mfront = 0; mclear = 0; mpend = 0; mwait = 0; mclrv = 0; exp_rd = 0;
  endtask

  // one clock of the reference: a clear is just "remaining pixels to fill"
  task automatic model_step;
    int back;
    back = 1 - mfront;
    exp_rd = mbank[mfront][{rd_y, rd_x}];
    if (mclear == 0 && !mwait) begin
      if (wr_valid) mbank[back][{wr_y, wr_x}] = wr_pix;
      if (clr_req) begin mclrv = clr_pix; mclear = 256; mpend = swap_req; end
      else if (swap_req) begin mpend = 1; mwait = 1; end
    end else if (mclear > 0) begin
      mbank[back][256 - mclear] = mclrv;
      mpend = mpend | swap_req;
      mclear--;
      if (mclear == 0 && mpend) mwait = 1;
    end else if (frame_end) begin
      mfront = 1 - mfront; mpend = 0; mwait = 0;
    end
  endtask

  task automatic tick;
    @(posedge clk);
    model_step();
    #1;
    wr_valid = 0; clr_req = 0; swap_req = 0; frame_end = 0;
  endtask

  task automatic read_all(input logic [1:0] want, input string tag);
    int bad = 0;
    logic [1:0] first_got = 0;
    for (int a = 0; a < 256; a++) begin
      {rd_y, rd_x} = 8'(a);
      tick();
      if (rd_pix !== want || rd_pix !== exp_rd) begin
        if (bad == 0) first_got = rd_pix;
        bad++;
      end
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s: %0d bad pixels, first got %0d required %0d", tag, bad, first_got, want);
    end
  endtask

  task automatic test_reset;
    rst_n = 0; wr_valid = 0; clr_req = 0; swap_req = 0; frame_end = 0;
    wr_x = 0; wr_y = 0; wr_pix = 0; clr_pix = 0; rd_x = 0; rd_y = 0;
    model_reset();
    #23 rst_n = 1;
    #4;
    n_chk++; if (front_bank !== 1'b0) begin n_fail++; $display("FAIL reset_front: got %0d required 0", front_bank); end
    n_chk++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready: got %0d required 1", wr_ready); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0d required 0", busy); end
    n_chk++; if (swap_pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending: got %0d required 0", swap_pending); end
    read_all(2'd0, "reset_read_all");
  endtask

  task automatic test_write_swap;
    wr_valid = 1; wr_x = 3; wr_y = 15; wr_pix = 3;
    tick();
    swap_req = 1;
    tick();
    n_chk++; if (swap_pending !== 1'b1) begin n_fail++; $display("FAIL ws_pending_set: got %0d required 1", swap_pending); end
    tick();
    frame_end = 1;
    tick();
    n_chk++; if (front_bank !== 1'b1) begin n_fail++; $display("FAIL ws_front: got %0d required 1", front_bank); end
    n_chk++; if (swap_pending !== 1'b0) begin n_fail++; $display("FAIL ws_pending_clr: got %0d required 0", swap_pending); end
    rd_x = 3; rd_y = 15;
    tick(); tick();
    n_chk++; if (rd_pix !== 2'd3) begin n_fail++; $display("FAIL ws_read: got %0d required 3", rd_pix); end
  endtask

  task automatic test_clear;
    int cycles = 0;
    int rdy_bad = 0;
    clr_req = 1; clr_pix = 2;
    tick();
    while (busy && cycles < 400) begin
      if (wr_ready !== 1'b0) rdy_bad++;
      cycles++;
      wr_valid = 1; wr_x = 4'($urandom); wr_y = 4'($urandom); wr_pix = 2'($urandom);
      tick();
    end
    n_chk++; if (cycles != 256) begin n_fail++; $display("FAIL clr_busy_len: got %0d required 256", cycles); end
    n_chk++; if (rdy_bad != 0) begin n_fail++; $display("FAIL clr_wr_ready: high in %0d cycles required 0", rdy_bad); end
    n_chk++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL clr_ready_after: got %0d required 1", wr_ready); end
    swap_req = 1; tick();
    frame_end = 1; tick();
    read_all(2'd2, "clr_read_all");
  endtask

  task automatic test_clear_swap;
    int orig = mfront;
    clr_req = 1; swap_req = 1; clr_pix = 2'($urandom);
    tick();
    for (int c = 1; c <= 310; c++) begin
      frame_end = (c == 100 || c == 300);
      tick();
      n_chk++;
      if (front_bank !== 1'(c >= 300 ? 1 - orig : orig)) begin
        n_fail++; $display("FAIL cs_front@%0d: got %0d required %0d", c, front_bank, c >= 300 ? 1 - orig : orig);
      end
      n_chk++;
      if (swap_pending !== (c < 300)) begin
        n_fail++; $display("FAIL cs_pending@%0d: got %0d required %0d", c, swap_pending, c < 300);
      end
    end
  endtask

  task automatic test_swap_frame_same;
    int orig = mfront;
    swap_req = 1; frame_end = 1;
    tick();
    n_chk++; if (front_bank !== 1'(orig)) begin n_fail++; $display("FAIL sf_no_toggle: got %0d required %0d", front_bank, orig); end
    n_chk++; if (swap_pending !== 1'b1) begin n_fail++; $display("FAIL sf_pending: got %0d required 1", swap_pending); end
    repeat (63) tick();
    frame_end = 1;
    tick();
    n_chk++; if (front_bank !== 1'(1 - orig)) begin n_fail++; $display("FAIL sf_toggle: got %0d required %0d", front_bank, 1 - orig); end
    n_chk++; if (swap_pending !== 1'b0) begin n_fail++; $display("FAIL sf_pending_clr: got %0d required 0", swap_pending); end
  endtask

  task automatic test_random;
    int bad_rd = 0, bad_ctl = 0;
    for (int i = 0; i < 3000; i++) begin
      wr_valid = ($urandom_range(1) == 1);
      wr_x = 4'($urandom); wr_y = 4'($urandom); wr_pix = 2'($urandom);
      clr_req = ($urandom_range(199) == 0); clr_pix = 2'($urandom);
      swap_req = ($urandom_range(29) == 0);
      frame_end = ($urandom_range(19) == 0);
      rd_x = 4'($urandom); rd_y = 4'($urandom);
      tick();
      n_chk++;
      if (rd_pix !== exp_rd) begin
        n_fail++;
        if (bad_rd++ < 5) $display("FAIL rnd_rd_pix@%0d: got %0d required %0d", i, rd_pix, exp_rd);
      end
      n_chk++;
      if (front_bank !== 1'(mfront) || swap_pending !== mpend || busy !== (mclear > 0 || mwait)
          || wr_ready !== !(mclear > 0 || mwait)) begin
        n_fail++;
        if (bad_ctl++ < 5)
          $display("FAIL rnd_ctl@%0d: got front=%0d pend=%0d busy=%0d rdy=%0d required front=%0d pend=%0d busy=%0d",
                   i, front_bank, swap_pending, busy, wr_ready, mfront, mpend, mclear > 0 || mwait);
      end
    end
  endtask

  task automatic test_reset_mid_clear;
    int n = 0;
    while (busy && n < 600) begin frame_end = 1; tick(); n++; end
    wr_valid = 1; wr_x = 7; wr_y = 9; wr_pix = 1;
    tick();
    clr_req = 1; clr_pix = 3;
    tick();
    repeat (49) tick();
    #2 rst_n = 0;
    #1;
    model_reset();
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmc_busy: got %0d required 0", busy); end
    n_chk++; if (front_bank !== 1'b0) begin n_fail++; $display("FAIL rmc_front: got %0d required 0", front_bank); end
    n_chk++; if (swap_pending !== 1'b0) begin n_fail++; $display("FAIL rmc_pending: got %0d required 0", swap_pending); end
    n_chk++; if (rd_pix !== 2'd0) begin n_fail++; $display("FAIL rmc_rd_pix: got %0d required 0", rd_pix); end
    n_chk++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL rmc_wr_ready: got %0d required 1", wr_ready); end
    #20 rst_n = 1;
    read_all(2'd0, "rmc_read_bank0");
    swap_req = 1; tick();
    frame_end = 1; tick();
    n_chk++; if (front_bank !== 1'b1) begin n_fail++; $display("FAIL rmc_swap: got %0d required 1", front_bank); end
    read_all(2'd0, "rmc_read_bank1");
  endtask

  initial begin
    test_reset();
    test_write_swap();
    test_clear();
    test_clear_swap();
    test_swap_frame_same();
    test_random();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
